// File: rtl/fp_alu_pkg.sv
// Shared opcodes, constants and types for the FP ALU arbiter.
package fp_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StResp
  } arb_state_e;

  typedef struct packed {
    logic exception;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/fp_alu_rr_arb.sv
// Two-way round-robin grant; the pointer moves to the non-owner on each accepted grant.
module fp_alu_rr_arb
  import fp_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (valid[ptr_q]) begin
      grant[ptr_q] = 1'b1;
    end else if (valid[~ptr_q]) begin
      grant[~ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~grant[1];
    end
  end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Shares one combinational FP ALU between two requesters with a held multicycle settle window.
// Optional statistics counters are built when FP_ALU_ARB_STATS_EN is defined.
module fp_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
`ifdef FP_ALU_ARB_STATS_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_A,
  input  logic [63:0] req_B,
  input  logic [5:0]  req_operation,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_Result,
  output logic        rsp_Exception,
  output logic        rsp_Overflow,
  output logic        rsp_Underflow,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_operation,
  input  logic [31:0] alu_Result,
  input  logic        alu_Exception,
  input  logic        alu_Overflow,
  input  logic        alu_Underflow
`ifdef FP_ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ops0,
  output logic [CNT_W-1:0] stat_ops1,
  output logic [CNT_W-1:0] stat_exc
`endif
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  fp_flags_t         rsp_flags_q, rsp_flags_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;

  logic [1:0]  grant;
  logic        accept;
  logic        sel;
  logic [31:0] sel_a, sel_b;
  logic [2:0]  sel_op;
  logic        rsp_hs;

  fp_alu_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready = (state_q == StIdle) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign sel       = grant[1];
  assign sel_a     = sel ? req_A[63:32] : req_A[31:0];
  assign sel_b     = sel ? req_B[63:32] : req_B[31:0];
  assign sel_op    = sel ? req_operation[5:3] : req_operation[2:0];
  // rsp_valid_q only ever carries the owner bit, so this is the owner's handshake.
  assign rsp_hs    = |(rsp_valid_q & rsp_ready);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_valid_d  = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = sel;
          if (op_is_legal(sel_op)) begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            cnt_d    = CntW'(SETTLE_CYCLES - 1);
            state_d  = StHold;
          end else begin
            // Illegal opcodes never reach the ALU; answer with a quiet NaN.
            rsp_result_d = QNAN;
            rsp_flags_d  = '{exception: 1'b1, overflow: 1'b0, underflow: 1'b0};
            state_d      = StResp;
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_Result;
          rsp_flags_d  = '{exception: alu_Exception, overflow: alu_Overflow,
                           underflow: alu_Underflow};
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_hs) begin
          state_d = StIdle;
        end else begin
          rsp_valid_d[owner_q] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign alu_A         = alu_a_q;
  assign alu_B         = alu_b_q;
  assign alu_operation = alu_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_Result    = rsp_result_q;
  assign rsp_Exception = rsp_flags_q.exception;
  assign rsp_Overflow  = rsp_flags_q.overflow;
  assign rsp_Underflow = rsp_flags_q.underflow;

`ifdef FP_ALU_ARB_STATS_EN
  logic [CNT_W-1:0] ops0_q, ops1_q, exc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops0_q <= '0;
      ops1_q <= '0;
      exc_q  <= '0;
    end else if (rsp_hs) begin
      if (!owner_q && ops0_q != '1) ops0_q <= ops0_q + CNT_W'(1);
      if (owner_q && ops1_q != '1)  ops1_q <= ops1_q + CNT_W'(1);
      if (rsp_flags_q.exception && exc_q != '1) exc_q <= exc_q + CNT_W'(1);
    end
  end

  assign stat_ops0 = ops0_q;
  assign stat_ops1 = ops1_q;
  assign stat_exc  = exc_q;
`endif

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Bench for fp_alu_arbiter: table-driven ops, scoreboard of expected responses, corner sequences.
module tb_fp_alu_arbiter;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_A, req_B;
  logic [5:0]  req_operation;
  logic [31:0] rsp_Result, alu_A, alu_B, alu_Result;
  logic        rsp_Exception, rsp_Overflow, rsp_Underflow;
  logic [2:0]  alu_operation;
  logic        alu_Exception, alu_Overflow, alu_Underflow;
`ifdef FP_ALU_ARB_STATS_EN
  logic [15:0] stat_ops0, stat_ops1, stat_exc;
`endif

  fp_alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_A         (req_A),
    .req_B         (req_B),
    .req_operation (req_operation),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_Result    (rsp_Result),
    .rsp_Exception (rsp_Exception),
    .rsp_Overflow  (rsp_Overflow),
    .rsp_Underflow (rsp_Underflow),
    .alu_A         (alu_A),
    .alu_B         (alu_B),
    .alu_operation (alu_operation),
    .alu_Result    (alu_Result),
    .alu_Exception (alu_Exception),
    .alu_Overflow  (alu_Overflow),
    .alu_Underflow (alu_Underflow)
`ifdef FP_ALU_ARB_STATS_EN
    ,
    .stat_ops0     (stat_ops0),
    .stat_ops1     (stat_ops1),
    .stat_exc      (stat_exc)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: knows only the operand sets used below.
  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;  // {exception, overflow, underflow}
  } alu_out_t;

  function automatic alu_out_t alu_stub(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case ({op, a, b})
      {3'b000, 32'h4000_0000, 32'h3F80_0000}: return '{32'h4040_0000, 3'b000};
      {3'b001, 32'h3F80_0000, 32'h4000_0000}: return '{32'hBF80_0000, 3'b000};
      {3'b010, 32'h4000_0000, 32'h4040_0000}: return '{32'h40C0_0000, 3'b000};
      {3'b011, 32'h40C0_0000, 32'h4000_0000}: return '{32'h4040_0000, 3'b000};
      {3'b010, 32'h7F00_0000, 32'h7F00_0000}: return '{32'h7F80_0000, 3'b010};
      {3'b010, 32'h0080_0000, 32'h0080_0000}: return '{32'h0000_0000, 3'b001};
      {3'b011, 32'h3F80_0000, 32'h0000_0000}: return '{32'h7F80_0000, 3'b100};
      {3'b000, 32'h4040_0000, 32'h4040_0000}: return '{32'h40C0_0000, 3'b000};
      default:                                return '{32'hDEAD_BEEF, 3'b000};
    endcase
  endfunction

  alu_out_t ao;
  always_comb ao = alu_stub(alu_A, alu_B, alu_operation);
  assign alu_Result    = ao.res;
  assign alu_Exception = ao.flg[2];
  assign alu_Overflow  = ao.flg[1];
  assign alu_Underflow = ao.flg[0];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  typedef struct {
    int          port;
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend[2];
  int   order[$];
  logic acc[2];
  logic prev_v = 1'b0;

  // Scoreboard: push on request handshake, pop/compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          if (!prev_v) check("rsp_latency", 64'(cyc - exp_q[0].cyc), 64'(exp_q[0].lat + 1));
          check("rsp_port", 64'(rsp_valid), 64'(2'b01 << exp_q[0].port));
          if (|(rsp_valid & rsp_ready)) begin
            check("rsp_result", 64'(rsp_Result), 64'(exp_q[0].res));
            check("rsp_flags", 64'({rsp_Exception, rsp_Overflow, rsp_Underflow}),
                  64'(exp_q[0].flg));
            void'(exp_q.pop_front());
          end
        end
      end
      if (|(req_valid & req_ready)) begin
        automatic int p = req_ready[1] ? 1 : 0;
        automatic exp_t e = pend[p];
        e.cyc = cyc;
        exp_q.push_back(e);
        order.push_back(p);
        acc[p] = 1'b1;
      end
    end
    prev_v = |rsp_valid;
  end

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] res, input logic [2:0] flg);
    pend[p] = '{port: p, res: res, flg: flg, lat: (op[2] ? 1 : SETTLE + 1), cyc: 0};
    req_A[p*32 +: 32]        = a;
    req_B[p*32 +: 32]        = b;
    req_operation[p*3 +: 3]  = op;
    acc[p]                   = 1'b0;
  endtask

  task automatic wait_acc(input int p);
    for (int n = 0; n < 100 && !acc[p]; n++) @(posedge clk);
    check("accept_seen", 64'(acc[p]), 64'(1));
    #1;
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] res, input logic [2:0] flg);
    logic [66:0] prev_alu;
    @(posedge clk); #1;
    prev_alu = {alu_A, alu_B, alu_operation};
    set_port(p, a, b, op, res, flg);
    req_valid[p] = 1'b1;
    wait_acc(p);
    req_valid[p] = 1'b0;
    if (op[2]) begin
      check("alu_kept_illegal", 64'({alu_A, alu_B}), prev_alu[66:3]);
    end else begin
      check("alu_latched", 64'({alu_A, alu_B}), {a, b});
      check("alu_op_latched", 64'(alu_operation), 64'(op));
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    order.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rsp_result"}, 64'(rsp_Result), 64'(0));
    check({tag, "_rsp_flags"}, 64'({rsp_Exception, rsp_Overflow, rsp_Underflow}), 64'(0));
    check({tag, "_alu_ab"}, 64'({alu_A, alu_B}), 64'(0));
    check({tag, "_alu_op"}, 64'(alu_operation), 64'(0));
  endtask

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'h4000_0000, 32'h3F80_0000, 3'b000, 32'h4040_0000, 3'b000};
    vecs[1] = '{1, 32'h3F80_0000, 32'h4000_0000, 3'b001, 32'hBF80_0000, 3'b000};
    vecs[2] = '{0, 32'h7F00_0000, 32'h7F00_0000, 3'b010, 32'h7F80_0000, 3'b010};
    vecs[3] = '{1, 32'h0080_0000, 32'h0080_0000, 3'b010, 32'h0000_0000, 3'b001};
    vecs[4] = '{0, 32'h3F80_0000, 32'h0000_0000, 3'b011, 32'h7F80_0000, 3'b100};
    vecs[5] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 32'h7FC0_0000, 3'b100};
    vecs[6] = '{0, 32'h4040_0000, 32'h4040_0000, 3'b000, 32'h40C0_0000, 3'b000};
    vecs[7] = '{0, 32'h5555_0000, 32'h0000_AAAA, 3'b110, 32'h7FC0_0000, 3'b100};

    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_A = '0;
    req_B = '0;
    req_operation = '0;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg);
      drain();
    end

    // Both ports at once from pointer 0: port 0 first, then port 1.
    do_reset();
    set_port(0, 32'h4000_0000, 32'h4040_0000, 3'b010, 32'h40C0_0000, 3'b000);
    set_port(1, 32'h40C0_0000, 32'h4000_0000, 3'b011, 32'h4040_0000, 3'b000);
    @(posedge clk); #1;
    req_valid = 2'b11;
    #1 check("both_grant", 64'(req_ready), 64'(2'b01));
    wait_acc(0);
    req_valid[0] = 1'b0;
    check("hold_no_ready", 64'(req_ready), 64'(0));
    wait_acc(1);
    req_valid[1] = 1'b0;
    drain();
    check("order_len", 64'(order.size()), 64'(2));
    if (order.size() == 2) begin
      check("order_first", 64'(order[0]), 64'(0));
      check("order_second", 64'(order[1]), 64'(1));
    end
    @(posedge clk); #1;
    req_valid = 2'b11;
    #1 check("ptr_back_to_0", 64'(req_ready), 64'(2'b01));
    req_valid = 2'b00;

    // Response back-pressure: result held, no new grant while port 1 waits.
    rsp_ready = 2'b10;
    issue(0, 32'h4000_0000, 32'h3F80_0000, 3'b000, 32'h4040_0000, 3'b000);
    set_port(1, 32'h4040_0000, 32'h4040_0000, 3'b000, 32'h40C0_0000, 3'b000);
    req_valid[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
    end
    for (int n = 0; n < 10; n++) begin
      check("stall_valid", 64'(rsp_valid), 64'(2'b01));
      check("stall_result", 64'(rsp_Result), 64'(32'h4040_0000));
      check("stall_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_acc(1);
    req_valid[1] = 1'b0;
    drain();

    // Reset in the middle of HOLD discards the operation.
    issue(0, 32'h4000_0000, 32'h4040_0000, 3'b010, 32'h40C0_0000, 3'b000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check_zero_outputs("midrst");
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("midrst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    issue(1, 32'h40C0_0000, 32'h4000_0000, 3'b011, 32'h4040_0000, 3'b000);
    drain();

`ifdef FP_ALU_ARB_STATS_EN
    do_reset();
    check("stat_clear", 64'({stat_ops0, stat_ops1, stat_exc}), 64'(0));
    issue(0, 32'h4000_0000, 32'h3F80_0000, 3'b000, 32'h4040_0000, 3'b000);
    drain();
    issue(0, 32'h3F80_0000, 32'h4000_0000, 3'b001, 32'hBF80_0000, 3'b000);
    drain();
    issue(0, 32'h4000_0000, 32'h4040_0000, 3'b010, 32'h40C0_0000, 3'b000);
    drain();
    issue(1, 32'h0000_0001, 32'h0000_0002, 3'b101, 32'h7FC0_0000, 3'b100);
    drain();
    @(negedge clk);
    check("stat_ops0", 64'(stat_ops0), 64'(3));
    check("stat_ops1", 64'(stat_ops1), 64'(1));
    check("stat_exc", 64'(stat_exc), 64'(1));
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_alu_arbiter.md
Name: fp_alu_arbiter

Overview:
- Shares one combinational 32-bit IEEE-754 ALU between two requesters (port 0, port 1).
- Round-robin arbitration; each port uses a valid/ready request channel and a valid/ready response channel.
- Registers the winning operands and holds them stable on the ALU inputs for a programmable settle window, so the long combinational path (mul/div) can be constrained as a multicycle path.
- Captures Result and the flags, then returns them to the owning requester.
- Sits between the issue logic and the shared ALU instance.

Parameters:
- SETTLE_CYCLES, 4, number of cycles the ALU inputs are held before capture (>=1).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  2  request valid, one bit per port.
- req_ready  out  2  request accepted, one bit per port.
- req_A  in  2x32  operand A per port (IEEE-754 single).
- req_B  in  2x32  operand B per port.
- req_operation  in  2x3  opcode per port: 000 add, 001 sub, 010 mul, 011 div.
- rsp_valid  out  2  response valid per port.
- rsp_ready  in  2  response accepted per port.
- rsp_Result  out  32  captured result, shared by both ports and qualified by rsp_valid.
- rsp_Exception, rsp_Overflow, rsp_Underflow  out  1 each  captured flags.
- alu_A, alu_B  out  32 each  driven to the shared ALU.
- alu_operation  out  3  driven to the shared ALU.
- alu_Result  in  32  from the ALU.
- alu_Exception, alu_Overflow, alu_Underflow  in  1 each  from the ALU.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = port 0; settle counter = 0.
- FSM states: IDLE, HOLD, RESP.
- IDLE:
  - req_ready is asserted combinationally, for the granted port only, when that port's req_valid is high.
  - Grant goes to the pointer port if it is valid, otherwise to the other port.
  - On a handshake edge: latch A, B and operation into the alu_* registers, record the owner, flip the pointer to the non-owner, load the counter with SETTLE_CYCLES-1, go to HOLD.
- HOLD:
  - alu_* outputs stay stable.
  - The counter decrements each cycle.
  - When the counter reaches 0: capture alu_Result and the flags into the rsp_* registers, go to RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES+1 edges after the accepting edge.
- RESP:
  - rsp_valid[owner] = 1.
  - Result and flags stay stable until rsp_ready[owner] is seen.
  - On that edge go to IDLE; rsp_valid drops the next cycle.
- req_ready is 0 in HOLD and RESP, so there is one outstanding operation at a time.
- Illegal opcode (1xx):
  - Accepted normally, but skips HOLD; goes to RESP next edge.
  - Response: Exception=1, Result=0x7FC00000 (qNaN), Overflow=0, Underflow=0.
  - alu_* registers are not updated.
- Both ports valid in IDLE: pointer port wins; the other is granted next, so there is no starvation.
- A requester dropping req_valid before its handshake is legal; no state change.
- rst during HOLD or RESP: the operation is discarded, no response is produced, all outputs return to reset values next cycle.
- alu_* outputs are registers only; no combinational path from req_* to alu_*.

Optional Feature:
- FP_ALU_ARB_STATS_EN defined:
  - Adds outputs stat_ops0, stat_ops1 (CNT_W each) and stat_exc (CNT_W).
  - stat_ops0/stat_ops1 increment on each completed response handshake for that port.
  - stat_exc increments when the completed response has Exception=1.
  - All three saturate at all-ones; cleared by rst.
- Undefined: those ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fp_alu_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - QNAN constant 0x7FC00000;
  - FSM state enum;
  - a flags typedef (Exception, Overflow, Underflow).
- One sub-module, fp_alu_rr_arb: 2-way round-robin grant from valid and pointer, with the pointer update on grant.

Test Plan:
- Port0 req A=0x40000000 B=0x3F800000 op=000, SETTLE_CYCLES=4 -> rsp_valid[0] exactly 5 edges after accept, Result=0x40400000, flags 0.
- Both ports valid same cycle (port0 mul 2.0*3.0, port1 div 6.0/2.0), pointer=0 -> port0 gets 0x40C00000 first, then port1 gets 0x40400000; pointer ends at port 0.
- Port1 op=101 -> response next edge, Exception=1, Result=0x7FC00000, alu_A/alu_B unchanged.
- rsp_ready[0] held low 10 cycles -> rsp_valid[0] and Result stay stable, req_ready=00 throughout, no new grant.
- rst asserted mid-HOLD -> next cycle all outputs 0, no rsp_valid; a subsequent request completes normally.
- With FP_ALU_ARB_STATS_EN: 3 port0 ops + 1 illegal port1 op -> stat_ops0=3, stat_ops1=1, stat_exc=1.
